// File: rtl/nmi_pkg.sv
// Shared types and constants for the two-master native memory interface arbiter.
// Request fields are sized for buses up to 32 bits wide.
package nmi_pkg;

  localparam int NMI_ADDR_W = 32;
  localparam int NMI_DATA_W = 32;
  localparam int NMI_STRB_W = NMI_DATA_W / 8;

  localparam logic [31:0] NMI_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [NMI_ADDR_W-1:0] addr;
    logic [NMI_DATA_W-1:0] wdata;
    logic [NMI_STRB_W-1:0] wstrb;
  } nmi_req_t;

endpackage

// File: rtl/nmi_arb_wdog.sv
// Per-grant watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYC-1 unless the slave hits.
// Expiry is combinational; sticky irq and saturating count update on the following edge.
module nmi_arb_wdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       hit_i,
  output logic       expire_o,
  output logic       irq_o,
  output logic [7:0] cnt_o
);

  localparam int WD_W = 16;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            irq_q, irq_d;
  logic [7:0]      cnt_q, cnt_d;

  // A slave response in the expiry cycle suppresses the timeout entirely.
  assign expire_o = en_i && !hit_i && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d  = en_i ? wd_q + 1'b1 : '0;
    irq_d = irq_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      irq_d = 1'b0;
    end
    if (expire_o) begin
      irq_d = 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      irq_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wd_q  <= wd_d;
      irq_q <= irq_d;
      cnt_q <= cnt_d;
    end
  end

  assign irq_o = irq_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/nmi_arb2.sv
// Round-robin arbiter sharing one nmi slave between two masters, grant held for a whole transaction.
// Slave request one cycle after master request; ready passes straight through; watchdog aborts stuck grants.
module nmi_arb2
  import nmi_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(NMI_ERR_RDATA)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_ready_o,
  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_ready_o,
  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ready_i,
  output logic                tmo_irq_o,
  input  logic                tmo_clr_i,
  output logic [7:0]          tmo_cnt_o
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_ptr_q, rr_ptr_d;

  nmi_req_t    req0, req1, req_sel;
  logic        own_vld;
  logic        wd_en;
  logic        expire;
  logic        done;
  logic [DATA_W-1:0] rsp_dat;

  assign req0 = '{addr:  NMI_ADDR_W'(m0_addr_i),
                  wdata: NMI_DATA_W'(m0_wdata_i),
                  wstrb: NMI_STRB_W'(m0_wstrb_i)};
  assign req1 = '{addr:  NMI_ADDR_W'(m1_addr_i),
                  wdata: NMI_DATA_W'(m1_wdata_i),
                  wstrb: NMI_STRB_W'(m1_wstrb_i)};

  assign req_sel = owner_q ? req1 : req0;
  assign own_vld = owner_q ? m1_valid_i : m0_valid_i;
  assign wd_en   = (state_q == GRANT) && own_vld;

  nmi_arb_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (tmo_clr_i),
    .en_i    (wd_en),
    .hit_i   (s_ready_i),
    .expire_o(expire),
    .irq_o   (tmo_irq_o),
    .cnt_o   (tmo_cnt_o)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    done      = 1'b0;
    rsp_dat   = '0;
    s_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          owner_d = (m0_valid_i && m1_valid_i) ? rr_ptr_q : m1_valid_i;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_valid_o = own_vld && !expire;
        if (s_ready_i) begin
          done     = 1'b1;
          rsp_dat  = s_rdata_i;
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end else if (expire) begin
          done     = 1'b1;
          rsp_dat  = ERR_RDATA;
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end else if (!own_vld) begin
          // Owner withdrew mid-transaction: drop it without a response or pointer change.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign s_addr_o  = ADDR_W'(req_sel.addr);
  assign s_wdata_o = DATA_W'(req_sel.wdata);
  assign s_wstrb_o = (state_q == GRANT) ? (DATA_W/8)'(req_sel.wstrb) : '0;

  assign m0_ready_o = done && !owner_q;
  assign m1_ready_o = done && owner_q;
  assign m0_rdata_o = m0_ready_o ? rsp_dat : '0;
  assign m1_rdata_o = m1_ready_o ? rsp_dat : '0;

endmodule

// File: tb/tb_nmi_arb2.sv
// Directed, table-driven bench for nmi_arb2 with an 8-cycle watchdog.
module tb_nmi_arb2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_valid_i, m1_valid_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_wstrb_i, m1_wstrb_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ready_o, m1_ready_o;
  logic        s_valid_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic [31:0] s_rdata_i;
  logic        s_ready_i;
  logic        tmo_irq_o, tmo_clr_i;
  logic [7:0]  tmo_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  nmi_arb2 #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .tmo_irq_o(tmo_irq_o), .tmo_clr_i(tmo_clr_i), .tmo_cnt_o(tmo_cnt_o)
  );

  typedef struct {
    bit          m0v;
    logic [31:0] m0a;
    bit          m1v;
    logic [31:0] m1a;
    logic [31:0] m1d;
    logic [3:0]  m1s;
    bit          srdy;
    logic [31:0] srd;
    bit          esv;
    logic [31:0] esa;
    logic [31:0] esd;
    logic [3:0]  ess;
    bit          e0r;
    logic [31:0] e0d;
    bit          e1r;
    logic [31:0] e1d;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit m0v, input logic [31:0] m0a, input bit m1v,
                       input logic [31:0] m1a, input logic [31:0] m1d, input logic [3:0] m1s,
                       input bit srdy, input logic [31:0] srd);
    m0_valid_i = m0v; m0_addr_i = m0a; m0_wdata_i = '0; m0_wstrb_i = '0;
    m1_valid_i = m1v; m1_addr_i = m1a; m1_wdata_i = m1d; m1_wstrb_i = m1s;
    s_ready_i  = srdy; s_rdata_i = srd;
  endtask

  // m0 read held through 8 GRANT cycles; optional slave hit or irq clear in the last one.
  task automatic m0_hold(input bit race, input bit clr, input bit vrb, input string tag);
    drive(1, 32'h2000, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    if (vrb) chk({tag, " idle svld"}, s_valid_o, 0);
    cyc();
    for (int g = 1; g <= 8; g++) begin
      if (g == 8) begin
        s_ready_i = race;
        s_rdata_i = 32'h0000_1234;
        tmo_clr_i = clr;
      end
      @(negedge clk_i);
      if (vrb) begin
        if (g < 8) begin
          chk($sformatf("%s g%0d svld", tag, g), s_valid_o, 1);
          chk($sformatf("%s g%0d m0rdy", tag, g), m0_ready_o, 0);
        end else begin
          chk({tag, " last m0rdy"}, m0_ready_o, 1);
          chk({tag, " last m0rdata"}, m0_rdata_o, race ? 32'h0000_1234 : 32'hDEAD_BEEF);
          chk({tag, " last svld"}, s_valid_o, race);
        end
        chk($sformatf("%s g%0d m1rdy", tag, g), m1_ready_o, 0);
      end
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tmo_clr_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    //             m0v m0a       m1v m1a       m1d       m1s   srdy srd      esv esa       esd       ess   e0r e0d      e1r e1d
    vecs[0]  = '{1, 32'h100,  1, 32'h200,  32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[1]  = '{1, 32'h100,  1, 32'h200,  32'h0,  4'h0, 1, 32'hA0, 1, 32'h100,  32'h0,  4'h0, 1, 32'hA0, 0, 32'h0};
    vecs[2]  = '{0, 32'h0,    1, 32'h200,  32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[3]  = '{0, 32'h0,    1, 32'h200,  32'h0,  4'h0, 1, 32'hB1, 1, 32'h200,  32'h0,  4'h0, 0, 32'h0,  1, 32'hB1};
    vecs[4]  = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[5]  = '{1, 32'h1000, 0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[6]  = '{1, 32'h1000, 0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  1, 32'h1000, 32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[7]  = '{1, 32'h1000, 0, 32'h0,    32'h0,  4'h0, 1, 32'h68, 1, 32'h1000, 32'h0,  4'h0, 1, 32'h68, 0, 32'h0};
    vecs[8]  = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[9]  = '{1, 32'h300,  1, 32'h400,  32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[10] = '{1, 32'h300,  1, 32'h400,  32'h0,  4'h0, 1, 32'hC2, 1, 32'h400,  32'h0,  4'h0, 0, 32'h0,  1, 32'hC2};
    vecs[11] = '{1, 32'h300,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[12] = '{1, 32'h300,  0, 32'h0,    32'h0,  4'h0, 1, 32'hD3, 1, 32'h300,  32'h0,  4'h0, 1, 32'hD3, 0, 32'h0};
    vecs[13] = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[14] = '{0, 32'h0,    1, 32'h4000, 32'h1F, 4'hF, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[15] = '{0, 32'h0,    1, 32'h4000, 32'h1F, 4'hF, 0, 32'h0,  1, 32'h4000, 32'h1F, 4'hF, 0, 32'h0,  0, 32'h0};
    vecs[16] = '{0, 32'h0,    1, 32'h4000, 32'h1F, 4'hF, 1, 32'h55, 1, 32'h4000, 32'h1F, 4'hF, 0, 32'h0,  1, 32'h55};
    vecs[17] = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 1, 32'h77, 0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[18] = '{1, 32'h800,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[19] = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[20] = '{1, 32'h500,  1, 32'h600,  32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[21] = '{1, 32'h500,  1, 32'h600,  32'h0,  4'h0, 1, 32'hE4, 1, 32'h500,  32'h0,  4'h0, 1, 32'hE4, 0, 32'h0};
    vecs[22] = '{0, 32'h0,    1, 32'h600,  32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};
    vecs[23] = '{0, 32'h0,    1, 32'h600,  32'h0,  4'h0, 1, 32'hF5, 1, 32'h600,  32'h0,  4'h0, 0, 32'h0,  1, 32'hF5};
    vecs[24] = '{0, 32'h0,    0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0,    32'h0,  4'h0, 0, 32'h0,  0, 32'h0};

    rst_i = 1'b1;
    tmo_clr_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst svld", s_valid_o, 0);
    chk("rst m0rdy", m0_ready_o, 0);
    chk("rst m1rdy", m1_ready_o, 0);
    chk("rst m0rdata", m0_rdata_o, 0);
    chk("rst irq", tmo_irq_o, 0);
    chk("rst cnt", tmo_cnt_o, 0);
    cyc();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].m0v, vecs[i].m0a, vecs[i].m1v, vecs[i].m1a, vecs[i].m1d, vecs[i].m1s,
            vecs[i].srdy, vecs[i].srd);
      @(negedge clk_i);
      chk($sformatf("v%0d svld", i), s_valid_o, vecs[i].esv);
      chk($sformatf("v%0d swstrb", i), s_wstrb_o, vecs[i].ess);
      chk($sformatf("v%0d m0rdy", i), m0_ready_o, vecs[i].e0r);
      chk($sformatf("v%0d m0rdata", i), m0_rdata_o, vecs[i].e0d);
      chk($sformatf("v%0d m1rdy", i), m1_ready_o, vecs[i].e1r);
      chk($sformatf("v%0d m1rdata", i), m1_rdata_o, vecs[i].e1d);
      if (vecs[i].esv) begin
        chk($sformatf("v%0d saddr", i), s_addr_o, vecs[i].esa);
        chk($sformatf("v%0d swdata", i), s_wdata_o, vecs[i].esd);
      end
      cyc();
    end

    m0_hold(0, 0, 1, "tmo");
    @(negedge clk_i);
    chk("tmo irq set", tmo_irq_o, 1);
    chk("tmo cnt 1", tmo_cnt_o, 1);
    chk("tmo idle svld", s_valid_o, 0);
    cyc();
    tmo_clr_i = 1'b1;
    cyc();
    tmo_clr_i = 1'b0;
    @(negedge clk_i);
    chk("clr irq", tmo_irq_o, 0);
    chk("clr keeps cnt", tmo_cnt_o, 1);
    cyc();

    m0_hold(1, 0, 1, "race");
    @(negedge clk_i);
    chk("race cnt", tmo_cnt_o, 1);
    chk("race irq", tmo_irq_o, 0);
    cyc();

    m0_hold(0, 1, 1, "clrwin");
    @(negedge clk_i);
    chk("clrwin irq", tmo_irq_o, 1);
    chk("clrwin cnt", tmo_cnt_o, 2);
    cyc();

    for (int k = 0; k < 253; k++) m0_hold(0, 0, 0, "sat");
    @(negedge clk_i);
    chk("sat cnt 255", tmo_cnt_o, 255);
    cyc();
    m0_hold(0, 0, 0, "sat");
    @(negedge clk_i);
    chk("sat hold 255", tmo_cnt_o, 255);
    cyc();

    drive(0, 0, 1, 32'h600, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("mrst idle svld", s_valid_o, 0);
    cyc();
    @(negedge clk_i);
    chk("mrst grant svld", s_valid_o, 1);
    chk("mrst grant saddr", s_addr_o, 32'h600);
    cyc();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("mrst rstcyc m0rdy", m0_ready_o, 0);
    chk("mrst rstcyc m1rdy", m1_ready_o, 0);
    cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mrst after svld", s_valid_o, 0);
    chk("mrst after m0rdy", m0_ready_o, 0);
    chk("mrst after m1rdy", m1_ready_o, 0);
    chk("mrst after irq", tmo_irq_o, 0);
    chk("mrst after cnt", tmo_cnt_o, 0);
    cyc();
    drive(1, 32'h500, 1, 32'h600, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("mrst coll idle svld", s_valid_o, 0);
    cyc();
    s_ready_i = 1'b1;
    s_rdata_i = 32'h99;
    @(negedge clk_i);
    chk("mrst coll saddr", s_addr_o, 32'h500);
    chk("mrst coll m0rdy", m0_ready_o, 1);
    chk("mrst coll m0rdata", m0_rdata_o, 32'h99);
    chk("mrst coll m1rdy", m1_ready_o, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nmi_arb2.md
Name: nmi_arb2

Overview:
- Two-master, one-slave arbiter on the native memory interface (nmi: valid/ready/addr/wdata/wstrb/rdata).
- Shares the native peripheral register block (GPIO/UART/timers/PSRAM and SPI-SD config) between the CPU and a secondary master (DMA or debug).
- Round-robin grant, held for one complete transaction.
- A watchdog terminates transactions the slave never acknowledges, e.g. a UART data read that stalls indefinitely.

Parameters:
- ADDR_W, 32, address width of the nmi bus.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT_CYC, 1024, cycles in GRANT without slave ready before abort; legal range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned to the master on timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- m0_valid_i  in  1  master 0 request
- m0_addr_i  in  ADDR_W  master 0 address
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_wstrb_i  in  DATA_W/8  master 0 byte strobes; 0 means read
- m0_rdata_o  out  DATA_W  master 0 read data
- m0_ready_o  out  1  master 0 completion pulse
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o, m1_ready_o: same as master 0, for master 1
- s_valid_o  out  1  slave request
- s_addr_o  out  ADDR_W  slave address
- s_wdata_o  out  DATA_W  slave write data
- s_wstrb_o  out  DATA_W/8  slave strobes
- s_rdata_i  in  DATA_W  slave read data
- s_ready_i  in  1  slave completion pulse
- tmo_irq_o  out  1  sticky timeout flag, level
- tmo_clr_i  in  1  clears tmo_irq_o
- tmo_cnt_o  out  8  saturating count of timeouts

Behaviour:
- Reset is synchronous and active-high on clk_i. While rst_i is high at a clock edge, every state register is cleared:
  - state is IDLE, owner is 0, rr_ptr is 0 (master 0 preferred), watchdog is 0, tmo_irq_o is 0, tmo_cnt_o is 0.
  - All ready outputs and s_valid_o therefore read 0.
  - Reset mid-transaction drops s_valid_o without issuing any ready.
- States:
  - IDLE: s_valid_o is 0 and s_wstrb_o is 0.
    - If exactly one mX_valid_i is high, owner is set to X.
    - If both are high, owner is set to rr_ptr.
    - In both cases the next state is GRANT and the watchdog is set to 0.
  - GRANT: s_addr_o, s_wdata_o and s_wstrb_o come combinationally from the owner's inputs; s_valid_o equals the owner's valid.
    - s_ready_i high: the owner's ready_o is high for that cycle and its rdata_o equals s_rdata_i. rr_ptr becomes ~owner. Next state is IDLE.
    - Watchdog reaches TIMEOUT_CYC-1 without s_ready_i: the owner's ready_o is high for that cycle and its rdata_o equals ERR_RDATA. s_valid_o is forced to 0 in that cycle. tmo_irq_o is set, tmo_cnt_o increments and saturates at 255, rr_ptr becomes ~owner. Next state is IDLE.
    - Owner drops valid before ready (protocol violation): abort silently to IDLE. No ready is issued and rr_ptr is unchanged.
    - Otherwise the watchdog increments.
  - s_ready_i in the same cycle as the timeout: the slave response wins; no timeout is recorded.
- The non-owner's ready_o is always 0. Each master's rdata_o holds 0 except in that master's ready cycle.
- s_ready_i in IDLE is ignored.
- Latency: a request seen at edge n drives s_valid_o from cycle n+1. The native wrapper acknowledges one cycle later, so the minimum master-visible latency is 2 cycles.
- A master holds valid and its payload stable until its ready. It deasserts valid the cycle after ready, as PicoRV32 masters do.
- Because of the return to IDLE, back-to-back grants are separated by at least one IDLE cycle. This matches the wrapper's one-cycle ready/valid guard.
- tmo_clr_i clears tmo_irq_o. A timeout in the same cycle as tmo_clr_i wins: the flag stays set. tmo_clr_i does not clear tmo_cnt_o; only reset does.

Decomposition:
- Shared package nmi_pkg:
  - typedef arb_state_e {IDLE, GRANT};
  - typedef nmi_req_t {addr, wdata, wstrb};
  - constant NMI_ERR_RDATA.
- Sub-module nmi_arb_wdog: watchdog counter plus sticky flag and saturating count. Inputs: clear, enable, hit; outputs: expire, irq, cnt.
- Everything else stays flat in nmi_arb2.

Test Plan:
1. Single master: m0 reads 0x0000_1000 with wstrb 0; slave model returns 0x0000_0068 after 1 cycle. Required: m0_ready_o pulses in cycle 2, m0_rdata_o = 0x68, m1_ready_o stays 0.
2. Contention after reset: m0 and m1 assert valid in the same cycle. Required: m0 is served first, then m1, with one IDLE cycle between grants. A repeat of the collision serves m1 first (rr_ptr alternates).
3. Write forwarding: m1 writes addr 0x4000, wdata 0x1F, wstrb 0xF. Required: the slave sees s_addr_o 0x4000, s_wdata_o 0x1F and s_wstrb_o 0xF while s_valid_o is high; m1_ready_o pulses once.
4. Timeout: TIMEOUT_CYC = 8 and the slave never asserts ready. Required: m0_ready_o rises in the 8th GRANT cycle with rdata 0xDEADBEEF. s_valid_o is 0 in that cycle. tmo_irq_o is 1 and tmo_cnt_o is 1. Pulsing tmo_clr_i clears the flag while the count stays 1.
5. Race: s_ready_i arrives in the same cycle as watchdog expiry. Required: the slave data is returned and tmo_cnt_o is unchanged.
6. Reset mid-GRANT: rst_i held high for 1 cycle. Required: s_valid_o is 0 and both readies are 0 on the next cycle. The state is IDLE, and a later simultaneous request grants m0.
